// File: rtl/reg_status_table_if.sv
// Dispatch, writeback-clear and lookup bundle for the register status table.
// The master side belongs to the issue stage and the slave side to the table.
interface reg_status_table_if #(
  parameter int NREGS = 32,
  parameter int TAG_W = 2,
  parameter int NWB   = 2,
  parameter int NRD   = 3
);
  localparam int IDX_W = $clog2(NREGS);

  logic                 flush;
  logic                 di_en;
  logic [IDX_W-1:0]     di_rd;
  logic [TAG_W-1:0]     di_tag;
  logic                 di_ready;
  logic [NWB-1:0]       wb_en;
  logic [NWB*IDX_W-1:0] wb_rd;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NRD*IDX_W-1:0] rd_idx;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic [NRD-1:0]       rd_fwd;
  logic [IDX_W:0]       busy_cnt;

  modport master (
    output flush, di_en, di_rd, di_tag, wb_en, wb_rd, wb_tag, rd_idx,
    input  di_ready, rd_busy, rd_tag, rd_fwd, busy_cnt
  );

  modport slave (
    input  flush, di_en, di_rd, di_tag, wb_en, wb_rd, wb_tag, rd_idx,
    output di_ready, rd_busy, rd_tag, rd_fwd, busy_cnt
  );
endinterface

// File: rtl/reg_status_table.sv
// Per-register pending-result tracker with tag-checked multi-port writeback
// clear, same-cycle forwarding indication, flush and a running busy count.
module reg_status_table #(
  parameter int NREGS    = 32,
  parameter int TAG_W    = 2,
  parameter int NWB      = 2,
  parameter int NRD      = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input logic CLK,
  input logic nRST,
  reg_status_table_if.slave bus
);
  localparam int IDX_W = $clog2(NREGS);

  logic [NREGS-1:0]            busy_q, busy_d, clear_hit;
  logic [NREGS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W:0]              cnt_q, cnt_d;
  logic                        zero_dst, accept;
  logic [NRD-1:0]              rd_busy_c, rd_fwd_c;
  logic [NRD*TAG_W-1:0]        rd_tag_c;
  logic [IDX_W-1:0]            lk_idx;

  // A writeback only clears an entry still owned by the same tag, so a stale
  // writeback from an earlier producer cannot release a newer reservation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    clear_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      for (int p = 0; p < NWB; p++) begin
        if (bus.wb_en[p] && (bus.wb_rd[p*IDX_W +: IDX_W] == IDX_W'(i)) && busy_q[i] &&
            (bus.wb_tag[p*TAG_W +: TAG_W] == tag_q[i]))
          clear_hit[i] = 1'b1;
      end
    end
  end

  assign zero_dst     = ZERO_REG && (bus.di_rd == '0);
  assign bus.di_ready = !busy_q[bus.di_rd] || clear_hit[bus.di_rd] || zero_dst;
  assign accept       = bus.di_en && bus.di_ready && !bus.flush;

  // Priority inside the next-state: flush over dispatch over clear.
  always_comb begin
    busy_d = busy_q & ~clear_hit;
    tag_d  = tag_q;
    if (accept && !zero_dst) begin
      busy_d[bus.di_rd] = 1'b1;
      tag_d[bus.di_rd]  = bus.di_tag;
    end
    if (bus.flush) begin
      busy_d = '0;
      tag_d  = '0;
    end
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_d = cnt_d + (IDX_W+1)'(busy_d[i]);
  end

  // The table is small and lookups expose tags directly, so tags are reset too.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      busy_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry 0 of a zero-register file is never written, so it reads back idle.
  always_comb begin
    rd_busy_c = '0;
    rd_fwd_c  = '0;
    rd_tag_c  = '0;
    lk_idx    = '0;
    for (int k = 0; k < NRD; k++) begin
      lk_idx                     = bus.rd_idx[k*IDX_W +: IDX_W];
      rd_busy_c[k]               = busy_q[lk_idx];
      rd_fwd_c[k]                = clear_hit[lk_idx];
      rd_tag_c[k*TAG_W +: TAG_W] = tag_q[lk_idx];
    end
  end

  assign bus.rd_busy  = rd_busy_c;
  assign bus.rd_fwd   = rd_fwd_c;
  assign bus.rd_tag   = rd_tag_c;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_status_table.sv
// Directed bench for reg_status_table: a scalar (32-entry, zero-register)
// instance and a matrix (16-entry, all trackable) instance.
module tb_reg_status_table;
  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  reg_status_table_if #(.NREGS(32), .TAG_W(2), .NWB(2), .NRD(3)) s_if ();
  reg_status_table_if #(.NREGS(16), .TAG_W(2), .NWB(2), .NRD(3)) m_if ();

  reg_status_table #(.NREGS(32), .TAG_W(2), .NWB(2), .NRD(3), .ZERO_REG(1'b1)) dut_s (
    .CLK(CLK), .nRST(nRST), .bus(s_if.slave)
  );
  reg_status_table #(.NREGS(16), .TAG_W(2), .NWB(2), .NRD(3), .ZERO_REG(1'b0)) dut_m (
    .CLK(CLK), .nRST(nRST), .bus(m_if.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic set_rd(input int k, input logic [4:0] idx);
    s_if.rd_idx[k*5 +: 5] = idx;
  endtask

  task automatic set_wb(input int p, input logic en, input logic [4:0] rd, input logic [1:0] tag);
    s_if.wb_en[p]         = en;
    s_if.wb_rd[p*5 +: 5]  = rd;
    s_if.wb_tag[p*2 +: 2] = tag;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [1:0] tag);
    s_if.di_en  = 1'b1;
    s_if.di_rd  = rd;
    s_if.di_tag = tag;
  endtask

  initial begin
    logic [1:0] tag_r;

    nRST = 1'b0;
    s_if.flush = 1'b0; s_if.wb_en = '0; s_if.wb_rd = '0; s_if.wb_tag = '0; s_if.rd_idx = '0;
    m_if.flush = 1'b0; m_if.wb_en = '0; m_if.wb_rd = '0; m_if.wb_tag = '0; m_if.rd_idx = '0;
    m_if.di_en = 1'b0; m_if.di_rd = '0; m_if.di_tag = '0;
    dispatch(5'd5, 2'd3);

    // Reset held two cycles while a dispatch is pending.
    tick(); tick();
    nRST = 1'b1;
    s_if.di_en = 1'b0;
    set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd5);
    settle();
    check("rst_busy", s_if.rd_busy, 0);
    check("rst_tag", s_if.rd_tag, 0);
    check("rst_fwd", s_if.rd_fwd, 0);
    check("rst_cnt", s_if.busy_cnt, 0);
    check("rst_ready", s_if.di_ready, 1);
    check("rst_cnt_m", m_if.busy_cnt, 0);

    // Dispatch r5 tag 2, then a WAW dispatch to r5 must stall.
    tick();
    dispatch(5'd5, 2'd2);
    settle();
    check("di_ready_idle", s_if.di_ready, 1);
    tick();
    s_if.di_en = 1'b0;
    settle();
    check("di_busy", s_if.rd_busy[0], 1);
    check("di_tag", s_if.rd_tag[1:0], 2);
    check("di_cnt", s_if.busy_cnt, 1);
    dispatch(5'd5, 2'd1);
    settle();
    check("waw_ready", s_if.di_ready, 0);
    tick();
    s_if.di_en = 1'b0;
    settle();
    check("waw_tag_kept", s_if.rd_tag[1:0], 2);
    check("waw_cnt_kept", s_if.busy_cnt, 1);

    // Stale writeback (wrong tag) is ignored; matching tag clears.
    set_wb(0, 1'b1, 5'd5, 2'd1);
    settle();
    check("stale_fwd", s_if.rd_fwd[0], 0);
    tick();
    set_wb(0, 1'b0, 5'd0, 2'd0);
    settle();
    check("stale_busy", s_if.rd_busy[0], 1);
    set_wb(1, 1'b1, 5'd5, 2'd2);
    s_if.di_rd = 5'd5;
    settle();
    check("clr_fwd", s_if.rd_fwd[0], 1);
    check("clr_ready", s_if.di_ready, 1);
    tick();
    set_wb(1, 1'b0, 5'd0, 2'd0);
    settle();
    check("clr_busy", s_if.rd_busy[0], 0);
    check("clr_cnt", s_if.busy_cnt, 0);

    // Clear and dispatch on r7 in the same cycle: dispatch wins.
    dispatch(5'd7, 2'd1);
    tick();
    s_if.di_en = 1'b0;
    settle();
    check("r7_cnt", s_if.busy_cnt, 1);
    set_wb(0, 1'b1, 5'd7, 2'd1);
    dispatch(5'd7, 2'd3);
    set_rd(1, 5'd7);
    settle();
    check("cd_ready", s_if.di_ready, 1);
    check("cd_fwd", s_if.rd_fwd[1], 1);
    tick();
    s_if.di_en = 1'b0;
    set_wb(0, 1'b0, 5'd0, 2'd0);
    settle();
    check("cd_busy", s_if.rd_busy[1], 1);
    check("cd_tag", s_if.rd_tag[3:2], 3);
    check("cd_cnt", s_if.busy_cnt, 1);

    // Both ports clear r7 together: counted once.
    set_wb(0, 1'b1, 5'd7, 2'd3);
    set_wb(1, 1'b1, 5'd7, 2'd3);
    tick();
    s_if.wb_en = '0;
    settle();
    check("dual_busy", s_if.rd_busy[1], 0);
    check("dual_cnt", s_if.busy_cnt, 0);

    // Register 0 of the scalar file never becomes busy; the matrix one does.
    dispatch(5'd0, 2'd3);
    set_rd(2, 5'd0);
    m_if.di_en = 1'b1; m_if.di_rd = 4'd0; m_if.di_tag = 2'd3;
    settle();
    check("z_ready", s_if.di_ready, 1);
    tick();
    s_if.di_en = 1'b0;
    m_if.di_en = 1'b0;
    settle();
    check("z_busy", s_if.rd_busy[2], 0);
    check("z_tag", s_if.rd_tag[5:4], 0);
    check("z_cnt", s_if.busy_cnt, 0);
    check("m0_busy", m_if.rd_busy[0], 1);
    check("m0_tag", m_if.rd_tag[1:0], 3);
    check("m0_cnt", m_if.busy_cnt, 1);
    m_if.di_en = 1'b1;
    settle();
    check("m0_waw", m_if.di_ready, 0);
    m_if.di_en = 1'b0;

    // Fill every non-zero scalar register, tag = low bits of the index.
    for (int r = 1; r < 32; r++) begin
      tag_r = r[1:0];
      dispatch(r[4:0], tag_r);
      tick();
    end
    s_if.di_en = 1'b0;
    set_rd(0, 5'd31); set_rd(1, 5'd6); set_rd(2, 5'd0);
    s_if.di_rd = 5'd9;
    settle();
    check("full_cnt", s_if.busy_cnt, 31);
    check("full_ready", s_if.di_ready, 0);
    check("full_tag31", s_if.rd_tag[1:0], 3);
    check("full_tag6", s_if.rd_tag[3:2], 2);
    check("full_busy0", s_if.rd_busy[2], 0);

    // Flush with an otherwise-acceptable dispatch and two matching clears.
    set_wb(0, 1'b1, 5'd4, 2'd0);
    set_wb(1, 1'b1, 5'd10, 2'd2);
    dispatch(5'd4, 2'd1);
    s_if.flush = 1'b1;
    settle();
    check("fl_ready", s_if.di_ready, 1);
    tick();
    s_if.flush = 1'b0;
    s_if.di_en = 1'b0;
    s_if.wb_en = '0;
    set_rd(0, 5'd4); set_rd(1, 5'd10); set_rd(2, 5'd31);
    settle();
    check("fl_cnt", s_if.busy_cnt, 0);
    check("fl_busy", s_if.rd_busy, 0);
    check("fl_tag", s_if.rd_tag, 0);

    // Synchronous reset mid-operation discards a pending dispatch.
    dispatch(5'd3, 2'd2);
    tick();
    dispatch(5'd8, 2'd1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    s_if.di_en = 1'b0;
    set_rd(0, 5'd3); set_rd(1, 5'd8);
    settle();
    check("mr_cnt", s_if.busy_cnt, 0);
    check("mr_busy", s_if.rd_busy, 0);
    check("mr_cnt_m", m_if.busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register status table (RST) for the scoreboarded dispatch/issue pipeline. It tracks, per architectural register, whether a result is pending and which functional-unit tag will produce it. One module covers both register files: scalar (32 entries, register 0 hard-wired idle) and matrix (16 entries). It adds three things the fixed scalar/matrix RST rows lack: multi-port tag-checked writeback clear, same-cycle forwarding indication, and flush.

## Interface
Parameters:
- NREGS, 32, number of tracked registers (power of two, ≥2); IDX_W = $clog2(NREGS)
- TAG_W, 2, width of functional-unit tag
- NWB, 2, number of writeback clear ports
- NRD, 3, number of lookup ports (rs1/rs2/rs3 or ms1/ms2/ms3)
- ZERO_REG, 1, 1 = entry 0 is never busy (scalar file); 0 = all entries trackable (matrix file)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- flush  in  1  clear every entry on the next edge
- di_en  in  1  dispatch request: mark di_rd busy with di_tag
- di_rd  in  IDX_W  destination register of dispatching instruction
- di_tag  in  TAG_W  producing FU tag
- di_ready  out  1  dispatch can be accepted this cycle (WAW check)
- wb_en  in  NWB  per-port writeback valid
- wb_rd  in  NWB*IDX_W  per-port written register
- wb_tag  in  NWB*TAG_W  per-port FU tag of the writer
- rd_idx  in  NRD*IDX_W  lookup indices
- rd_busy  out  NRD  registered busy bit of each looked-up entry
- rd_tag  out  NRD*TAG_W  registered tag of each looked-up entry
- rd_fwd  out  NRD  entry is busy and is being cleared by a writeback this cycle
- busy_cnt  out  IDX_W+1  number of busy entries (registered)

## Operation
- State: NREGS entries {busy, tag[TAG_W-1:0]} plus the busy_cnt register.
- Clear hit for entry i: some port p has wb_en[p], wb_rd[p]==i, busy[i], and wb_tag[p]==tag[i].
  - A tag mismatch, or a writeback to an idle entry, is ignored. This protects against stale writebacks.
- Several ports hitting the same entry: the clear is applied once; no error.
- di_ready = !busy[di_rd] | clear_hit[di_rd] | (ZERO_REG & di_rd==0). It is combinational and does not depend on di_en.
- Dispatch accepted = di_en & di_ready & !flush.
  - If accepted and !(ZERO_REG & di_rd==0): busy[di_rd]←1, tag[di_rd]←di_tag.
  - If di_en & !di_ready: no state change; the upstream stage holds.
- Dispatch and clear on the same entry in the same cycle: dispatch wins (busy=1, new tag).
- Priority at each edge: !nRST > flush > dispatch > clear.
- flush: all busy←0, tags←0, busy_cnt←0. Dispatch and clears in that cycle are discarded.
- Lookup (combinational from registered state): rd_busy[k]=busy[rd_idx[k]], rd_tag[k]=tag[rd_idx[k]], rd_fwd[k]=clear_hit[rd_idx[k]].
- With ZERO_REG=1, index 0 always returns busy=0, tag=0, fwd=0.
- busy_cnt←popcount of next-state busy vector. Width IDX_W+1 holds NREGS without wrap.

## Timing
- Reset: all entries busy=0/tag=0 on the first edge with nRST=0. Resulting outputs:
  - rd_busy=0, rd_tag=0, rd_fwd=0, busy_cnt=0.
  - di_ready=1.
- Dispatch accepted at edge k: rd_busy/rd_tag reflect it from cycle k+1; busy_cnt increments at edge k.
- Writeback clear in cycle k: rd_fwd=1 during cycle k; rd_busy=0 from cycle k+1.
  - A dispatch to that register is accepted in cycle k itself (di_ready=1).
- Table full (busy_cnt==NREGS, or NREGS-1 with ZERO_REG): no special behaviour. Further dispatches stall via di_ready only.
- Reset or flush asserted mid-operation: takes effect at that edge regardless of any pending di_en/wb_en.

## Test plan
- Reset: hold nRST=0 for 2 cycles with di_en=1, di_rd=5 → after release every rd_busy=0, busy_cnt=0, di_ready=1.
- Dispatch/lookup: di_rd=5, di_tag=2 → next cycle rd_idx=5 gives rd_busy=1, rd_tag=2, busy_cnt=1. Second di_en to rd 5 → di_ready=0, state unchanged.
- Tag-checked clear: entry 5 tag=2. wb port0 {5, tag 1} → ignored, rd_fwd=0. wb port1 {5, tag 2} → rd_fwd=1 that cycle, rd_busy=0 next, busy_cnt=0.
- Simultaneous clear+dispatch: entry 7 tag=1. Same cycle wb {7,1} and di {7, tag 3} → di_ready=1; next cycle busy=1, tag=3, busy_cnt unchanged.
- ZERO_REG: dispatch to rd 0 → di_ready=1, rd_busy[0] stays 0, busy_cnt stays 0. With ZERO_REG=0, NREGS=16: rd 0 becomes busy.
- Flush/fill: dispatch to all 31 non-zero scalar regs → busy_cnt=31. Assert flush together with a dispatch and two matching writebacks → next cycle busy_cnt=0 and all rd_busy=0.
